// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the 8-point FFT/IFFT datapath.
// Sample width, twiddle indices, 1/sqrt2 shift set and saturation bounds.
package fft_pkg;

   // Component width, signed Q1.15.
   localparam int DATA_W = 16;
   // Pre-add operand width (no truncation before scaling).
   localparam int OP_W   = DATA_W + 1;
   // Scaled-sum width.
   localparam int SUM_W  = DATA_W + 2;

   localparam logic [1:0] K_W0 = 2'd0;
   localparam logic [1:0] K_W1 = 2'd1;
   localparam logic [1:0] K_W2 = 2'd2;
   localparam logic [1:0] K_W3 = 2'd3;

   // 1/sqrt2 ~= 2^-1 + 2^-3 + 2^-4 + 2^-6 + 2^-8
   localparam int SH_A = 1;
   localparam int SH_B = 3;
   localparam int SH_C = 4;
   localparam int SH_D = 6;
   localparam int SH_E = 8;

   localparam logic signed [SUM_W-1:0] SAT_MAX =
      SUM_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN =
      SUM_W'(-(2 ** (DATA_W - 1)));

   function automatic logic signed [OP_W-1:0] sext_in(
      input logic signed [DATA_W-1:0] v
   );
      return {v[DATA_W-1], v};
   endfunction

   function automatic logic signed [SUM_W-1:0] sext_op(
      input logic signed [OP_W-1:0] v
   );
      return {v[OP_W-1], v};
   endfunction

   function automatic logic sat_clip(
      input logic signed [SUM_W-1:0] v
   );
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_val(
      input logic signed [SUM_W-1:0] v
   );
      if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
      if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      return v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/ifft_twiddle_w8_rsqrt2_scale.sv
// rsqrt2_scale: two-stage shift-add scaling of a signed operand by 1/sqrt2.
// Ports: clk, rst (sync, active-high), en_i (hold when low),
//   x_i operand in, x_o operand delayed two stages, y_o scaled sum.
module rsqrt2_scale
   import fft_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_i,
   input  logic signed [OP_W-1:0]  x_i,
   output logic signed [OP_W-1:0]  x_o,
   output logic signed [SUM_W-1:0] y_o
);

   logic signed [OP_W-1:0]  x1_q, x1_d;
   logic signed [OP_W-1:0]  x2_q, x2_d;
   logic signed [SUM_W-1:0] p13_q, p13_d;
   logic signed [SUM_W-1:0] p46_q, p46_d;
   logic signed [SUM_W-1:0] p8_q, p8_d;

   always_comb begin
      x1_d  = x_i;
      x2_d  = x1_q;
      p13_d = sext_op(x1_q >>> SH_A) + sext_op(x1_q >>> SH_B);
      p46_d = sext_op(x1_q >>> SH_C) + sext_op(x1_q >>> SH_D);
      p8_d  = sext_op(x1_q >>> SH_E);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x1_q  <= '0;
         x2_q  <= '0;
         p13_q <= '0;
         p46_q <= '0;
         p8_q  <= '0;
      end else if (en_i) begin
         x1_q  <= x1_d;
         x2_q  <= x2_d;
         p13_q <= p13_d;
         p46_q <= p46_d;
         p8_q  <= p8_d;
      end
   end

   // Final add is left combinational; the caller registers it.
   assign y_o = p13_q + p46_q + p8_q;
   assign x_o = x2_q;

endmodule

// File: rtl/ifft_twiddle_w8.sv
// ifft_twiddle_w8: 3-stage conjugate twiddle rotator, multiplies by W8^-k.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_re/in_im/in_k
//   input stream; out_valid/out_ready/out_re/out_im/out_ovf output stream.
// Build option: define TWIDDLE_SAT_EN to saturate results and flag out_ovf;
//   otherwise results wrap to DATA_W bits and out_ovf stays 0.
module ifft_twiddle_w8
   import fft_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   input  logic [1:0]               in_k,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_re,
   output logic signed [DATA_W-1:0] out_im,
   output logic                     out_ovf
);

   logic adv;

   logic       v1_q, v1_d;
   logic       v2_q, v2_d;
   logic       v3_q, v3_d;
   logic [1:0] k1_q, k1_d;
   logic [1:0] k2_q, k2_d;

   logic signed [OP_W-1:0]  re_s, im_s;
   logic signed [OP_W-1:0]  op_re, op_im;
   logic signed [OP_W-1:0]  pass_re, pass_im;
   logic signed [SUM_W-1:0] scl_re, scl_im;
   logic signed [SUM_W-1:0] fin_re, fin_im;
   logic                    use_scl;

   logic signed [DATA_W-1:0] re3_q, re3_d;
   logic signed [DATA_W-1:0] im3_q, im3_d;
   logic                     ovf3_q, ovf3_d;

   // Whole pipeline moves together; a full S3 blocks everything.
   assign adv      = ~v3_q | out_ready;
   assign in_ready = adv;

   // Pre-add at OP_W bits. For k=0/2 the operand is the passthrough
   // value itself; the scaler just carries it alongside.
   always_comb begin
      re_s  = sext_in(in_re);
      im_s  = sext_in(in_im);
      op_re = re_s;
      op_im = im_s;
      unique case (in_k)
         K_W0: begin
            op_re = re_s;
            op_im = im_s;
         end
         K_W1: begin
            op_re = re_s - im_s;
            op_im = re_s + im_s;
         end
         K_W2: begin
            op_re = -im_s;
            op_im = re_s;
         end
         K_W3: begin
            op_re = -re_s - im_s;
            op_im = re_s - im_s;
         end
      endcase
   end

   rsqrt2_scale u_scale_re (
      .clk  (clk),
      .rst  (rst),
      .en_i (adv),
      .x_i  (op_re),
      .x_o  (pass_re),
      .y_o  (scl_re)
   );

   rsqrt2_scale u_scale_im (
      .clk  (clk),
      .rst  (rst),
      .en_i (adv),
      .x_i  (op_im),
      .x_o  (pass_im),
      .y_o  (scl_im)
   );

   assign use_scl = (k2_q == K_W1) || (k2_q == K_W3);
   assign fin_re  = use_scl ? scl_re : sext_op(pass_re);
   assign fin_im  = use_scl ? scl_im : sext_op(pass_im);

   always_comb begin
      v1_d   = v1_q;
      v2_d   = v2_q;
      v3_d   = v3_q;
      k1_d   = k1_q;
      k2_d   = k2_q;
      re3_d  = re3_q;
      im3_d  = im3_q;
      ovf3_d = ovf3_q;
      if (adv) begin
         v1_d = in_valid;
         v2_d = v1_q;
         v3_d = v2_q;
         k1_d = in_k;
         k2_d = k1_q;
         // Bubbles leave the output data untouched.
         if (v2_q) begin
`ifdef TWIDDLE_SAT_EN
            re3_d  = sat_val(fin_re);
            im3_d  = sat_val(fin_im);
            ovf3_d = sat_clip(fin_re) | sat_clip(fin_im);
`else
            re3_d  = fin_re[DATA_W-1:0];
            im3_d  = fin_im[DATA_W-1:0];
            ovf3_d = 1'b0;
`endif
         end
      end
   end

`ifndef TWIDDLE_SAT_EN
   logic unused_hi;
   assign unused_hi = ^{fin_re[SUM_W-1:DATA_W],
                        fin_im[SUM_W-1:DATA_W]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         k1_q   <= K_W0;
         k2_q   <= K_W0;
         re3_q  <= '0;
         im3_q  <= '0;
         ovf3_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         k1_q   <= k1_d;
         k2_q   <= k2_d;
         re3_q  <= re3_d;
         im3_q  <= im3_d;
         ovf3_q <= ovf3_d;
      end
   end

   assign out_valid = v3_q;
   assign out_re    = re3_q;
   assign out_im    = im3_q;
   assign out_ovf   = ovf3_q;

endmodule

// File: tb/tb_ifft_twiddle_w8.sv
// tb_ifft_twiddle_w8: self-checking bench for ifft_twiddle_w8.
// Directed table, backpressure, throughput and mid-stream reset sequences.
module tb_ifft_twiddle_w8;
   import fft_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_re = '0;
   logic signed [DATA_W-1:0] in_im = '0;
   logic [1:0]               in_k = 2'd0;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic signed [DATA_W-1:0] out_re;
   logic signed [DATA_W-1:0] out_im;
   logic                     out_ovf;

   int tests = 0;
   int fails = 0;
   int nout  = 0;

   always #5 clk = ~clk;

   ifft_twiddle_w8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_k      (in_k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_ovf   (out_ovf)
   );

   typedef struct {
      int re;
      int im;
      int ovf;
   } res_t;

   typedef struct {
      int re;
      int im;
      int k;
      int ere;
      int eim;
      int eovf;
   } vec_t;

   res_t expq[$];
   vec_t tbl[$];

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Floor division: an arithmetic right shift by n is floor(x / 2^n).
   function automatic int fdiv(input int x, input int d);
      int q = x / d;
      if ((x % d != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int wrapn(input int x, input int bits);
      int span = 1 << bits;
      int m = x % span;
      if (m < 0) m = m + span;
      if (m >= span / 2) m = m - span;
      return m;
   endfunction

   function automatic int cs(input int x);
      return fdiv(x, 2) + fdiv(x, 8) + fdiv(x, 16)
           + fdiv(x, 64) + fdiv(x, 256);
   endfunction

   function automatic res_t model(input int re, input int im, input int k);
      res_t o;
      int r = re;
      int i = im;
      case (k)
         1: begin
            r = cs(wrapn(re - im, 17));
            i = cs(wrapn(re + im, 17));
         end
         2: begin
            r = -im;
            i = re;
         end
         3: begin
            r = cs(wrapn(-re - im, 17));
            i = cs(wrapn(re - im, 17));
         end
         default: ;
      endcase
      o.ovf = 0;
`ifdef TWIDDLE_SAT_EN
      if (r > 32767) begin r = 32767; o.ovf = 1; end
      else if (r < -32768) begin r = -32768; o.ovf = 1; end
      if (i > 32767) begin i = 32767; o.ovf = 1; end
      else if (i < -32768) begin i = -32768; o.ovf = 1; end
`else
      r = wrapn(r, 16);
      i = wrapn(i, 16);
`endif
      o.re = r;
      o.im = i;
      return o;
   endfunction

   function automatic int rnd16();
      logic [15:0] t;
      if ($urandom_range(0, 7) == 0)
         return ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      t = 16'($urandom);
      return int'($signed(t));
   endfunction

   // Scoreboard: every accepted input produces one in-order output.
   always @(negedge clk) begin : mon
      res_t e;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_out: got (%0d,%0d), expected none",
                        out_re, out_im);
            end else begin
               e = expq.pop_front();
               check("sb_re", int'(out_re), e.re);
               check("sb_im", int'(out_im), e.im);
               check("sb_ovf", int'(out_ovf), e.ovf);
               nout++;
            end
         end
         if (in_valid && in_ready)
            expq.push_back(model(int'(in_re), int'(in_im), int'(in_k)));
      end
   end

   task automatic drive_rand();
      in_valid = 1'b1;
      in_re    = DATA_W'(rnd16());
      in_im    = DATA_W'(rnd16());
      in_k     = 2'($urandom_range(0, 3));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      expq.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_re"}, int'(out_re), 0);
      check({tag, "_out_im"}, int'(out_im), 0);
      check({tag, "_out_ovf"}, int'(out_ovf), 0);
      check({tag, "_in_ready"}, int'(in_ready), 1);
   endtask

   initial begin : main
      int   lat;
      int   idx;
      int   cyc;
      int   n0;
      int   hr;
      int   hi;
      bit   have;
      bit   acc;

      tbl.push_back('{16384, 0, 1, 11584, 11584, 0});
      tbl.push_back('{16384, 0, 3, -11584, 11584, 0});
      tbl.push_back('{1000, -2000, 2, 2000, 1000, 0});
      tbl.push_back('{-5, 7, 0, -5, 7, 0});
      tbl.push_back('{0, 16384, 1, -11584, 11584, 0});
      tbl.push_back('{-100, -100, 3, 140, 0, 0});
`ifdef TWIDDLE_SAT_EN
      tbl.push_back('{32767, -32768, 1, 32767, -5, 1});
      tbl.push_back('{0, -32768, 2, 32767, 0, 1});
`else
      tbl.push_back('{32767, -32768, 1, -19205, -5, 0});
      tbl.push_back('{0, -32768, 2, -32768, 0, 0});
`endif

      do_reset();
      check_reset_state("reset");

      // Directed vectors, one at a time, with latency check.
      out_ready = 1'b1;
      foreach (tbl[n]) begin
         in_valid = 1'b1;
         in_re    = DATA_W'(tbl[n].re);
         in_im    = DATA_W'(tbl[n].im);
         in_k     = 2'(tbl[n].k);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check($sformatf("vec%0d_latency", n), lat, 3);
         check($sformatf("vec%0d_re", n), int'(out_re), tbl[n].ere);
         check($sformatf("vec%0d_im", n), int'(out_im), tbl[n].eim);
         check($sformatf("vec%0d_ovf", n), int'(out_ovf), tbl[n].eovf);
         @(posedge clk);
         #1;
      end

      // Backpressure: 8 samples, out_ready low for 5 cycles mid-stream.
      idx  = 0;
      cyc  = 0;
      n0   = nout;
      have = 1'b0;
      acc  = 1'b1;
      hr   = 0;
      hi   = 0;
      while ((idx < 8 || nout - n0 < 8) && cyc < 100) begin
         if (idx < 8) begin
            if (acc) drive_rand();
         end else begin
            in_valid = 1'b0;
         end
         out_ready = !(cyc >= 5 && cyc < 10);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (!out_ready) begin
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            if (have) begin
               check("bp_hold_re", int'(out_re), hr);
               check("bp_hold_im", int'(out_im), hi);
            end else begin
               hr   = int'(out_re);
               hi   = int'(out_im);
               have = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_accepted", idx, 8);
      check("bp_count", nout - n0, 8);

      // Full throughput: 32 back-to-back samples.
      n0 = nout;
      for (int c = 0; c < 32; c++) begin
         drive_rand();
         @(negedge clk);
         check("tp_in_ready", int'(in_ready), 1);
         if (c >= 3) check("tp_out_valid", int'(out_valid), 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("tp_drain_valid", int'(out_valid), 1);
         @(posedge clk);
         #1;
      end
      check("tp_count", nout - n0, 32);

      // Reset with two samples in flight.
      for (int c = 0; c < 2; c++) begin
         drive_rand();
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      expq.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("midrst");
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("midrst_no_stale", int'(out_valid), 0);
         @(posedge clk);
         #1;
      end

      check("sb_empty", expq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifft_twiddle_w8.md
Name: ifft_twiddle_w8

Overview:
- Pipelined conjugate-twiddle rotator for the inverse-FFT path of the 8-point transform.
- Multiplies one complex sample by W8^-k = exp(+j·2πk/8), k = 0..3, using only shift-add constant scaling by 1/√2.
- Sits between IFFT butterfly stages, the inverse-direction counterpart of the forward W8^k rotation.
- Valid/ready streaming with a fixed 3-cycle latency.

Parameters:
DATA_W, 16, sample width per component, signed two's complement Q1.15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_re  in  DATA_W  real part.
- in_im  in  DATA_W  imaginary part.
- in_k  in  2  twiddle index k.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_re  out  DATA_W  rotated real part.
- out_im  out  DATA_W  rotated imaginary part.
- out_ovf  out  1  saturation occurred on this sample.

Behaviour:
- Reset: one clock, synchronous active-high, named clk / rst.
  - rst=1 at a rising edge clears all stage valid bits and data registers.
  - out_valid=0, out_re=0, out_im=0, out_ovf=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-stream discards every in-flight sample; none is emitted afterwards.
- Rotation, with c(x) = (x>>>1)+(x>>>3)+(x>>>4)+(x>>>6)+(x>>>8):
  - Each shift is an arithmetic shift of a 17-bit signed operand.
  - The sum is formed at 18 bits.
  - k=0: re'=re, im'=im.
  - k=1: re'=c(re-im), im'=c(re+im).
  - k=2: re'=-im, im'=re.
  - k=3: re'=c(-re-im), im'=c(re-im).
- Pre-add widths: re±im and -re-im are computed at 17 bits, with no truncation before scaling.
- Pipeline: 3 register stages, one sample per cycle.
  - S1 registers the pre-add / negate operands and k.
  - S2 registers partial sums (t1+t3), (t4+t6) and t8.
  - S3 registers the final sum after saturation or wrap, plus ovf.
- k=0 and k=2 samples pass through the same 3 stages, so latency is constant.
- Handshake:
  - Global advance: adv = ~out_valid | out_ready; in_ready = adv.
  - A sample is accepted on in_valid & in_ready and appears at S3 exactly 3 advancing cycles later.
  - When adv=0 the whole pipeline holds; out_re/out_im/out_ovf/out_valid stay stable until out_ready.
  - Empty stages propagate as bubbles, with no bubble collapse.
- Simultaneous accept and emit in the same cycle is legal and sustains full throughput.
- in_* values are ignored when in_valid=0.

Optional Feature:
- Macro TWIDDLE_SAT_EN.
- Defined: the result is saturated to [-32768, 32767] per component, and out_ovf=1 if either component clipped.
- Undefined: the result is the low DATA_W bits (two's complement wrap), and out_ovf is tied to 0.

Decomposition:
- Shared package fft_pkg:
  - DATA_W.
  - Twiddle index constants K_W0..K_W3.
  - Shift-amount constants for 1/√2 (1,3,4,6,8).
  - SAT_MAX / SAT_MIN.
- One natural sub-module, rsqrt2_scale:
  - 17-bit signed operand in, 18-bit scaled result.
  - Two internal register stages with a hold-enable input.
  - Instantiated twice, once for re and once for im.

Test Plan:
- k=1, (16384, 0) -> (11584, 11584) exactly 3 cycles after accept, out_ovf=0.
- k=3, (16384, 0) -> (-11584, 11584); k=2, (1000, -2000) -> (2000, 1000); k=0, (-5, 7) -> (-5, 7).
- Saturation, TWIDDLE_SAT_EN defined:
  - k=1, (32767, -32768) -> (32767, -5), out_ovf=1.
  - k=2, (0, -32768) -> (32767, 0), out_ovf=1.
- Backpressure: stream 8 samples back-to-back, hold out_ready=0 for 5 cycles mid-stream.
  - Outputs stay stable while held.
  - in_ready=0 while out_valid=1 and out_ready=0.
  - All 8 results arrive in order with no loss or duplication.
- Full throughput: out_ready=1, in_valid=1 for 32 cycles with random k.
  - 32 outputs on consecutive cycles, bit-exact against the shift-add reference model.
- Reset mid-operation: assert rst for 1 cycle with 2 samples in flight.
  - The next cycle shows out_valid=0, outputs 0 and in_ready=1.
  - No stale sample appears later.
